// File: rtl/crypto_fu_xperm_seq.sv
// Multi-cycle RISC-V xperm4/xperm8 crossbar permute unit.
// Operands are captured on acceptance, and EPC result elements are resolved per BUSY cycle.
module crypto_fu_xperm_seq #(
  parameter int XLEN = 64,
  parameter int EPC  = 4
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            valid_i,
  output logic            ready_o,
  input  logic            op_xperm8_i,
  input  logic [XLEN-1:0] rs1_i,
  input  logic [XLEN-1:0] rs2_i,
  output logic            valid_o,
  input  logic            ready_i,
  output logic [XLEN-1:0] rd_o
);

  localparam int N4 = XLEN / 4;
  localparam int N8 = XLEN / 8;
  localparam int S4 = ((N4 / EPC) < 1) ? 1 : (N4 / EPC);
  localparam int S8 = ((N8 / EPC) < 1) ? 1 : (N8 / EPC);
  localparam logic [3:0] LAST4 = 4'(S4 - 1);
  localparam logic [3:0] LAST8 = 4'(S8 - 1);

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t          state_q, state_d;
  logic [3:0]      cnt_q;
  logic            op_q;
  logic [XLEN-1:0] rs1_q, rs2_q, res_q, res_d;
  logic            accept, last_step;
  int              pos, idx;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) state_q <= IDLE;
    else       state_q <= state_d;
  end

  // Handshake outputs decode the registered state only.
  always_comb begin
    state_d   = state_q;
    ready_o   = 1'b0;
    valid_o   = 1'b0;
    accept    = 1'b0;
    last_step = 1'b0;
    unique case (state_q)
      IDLE: begin
        ready_o = 1'b1;
        if (valid_i) begin
          accept  = 1'b1;
          state_d = BUSY;
        end
      end
      BUSY: begin
        last_step = (cnt_q == (op_q ? LAST8 : LAST4));
        if (last_step) state_d = DONE;
      end
      DONE: begin
        valid_o = 1'b1;
        if (ready_i) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Resolve the EPC elements selected by the step counter; indices past N give zero.
  always_comb begin
    res_d = res_q;
    pos   = 0;
    idx   = 0;
    for (int j = 0; j < EPC; j++) begin
      pos = int'(cnt_q) * EPC + j;
      if (op_q) begin
        if (pos < N8) begin
          idx = int'(rs1_q[pos*8 +: 8]);
          res_d[pos*8 +: 8] = (idx < N8) ? rs2_q[idx*8 +: 8] : 8'h00;
        end
      end else if (pos < N4) begin
        idx = int'(rs1_q[pos*4 +: 4]);
        res_d[pos*4 +: 4] = (idx < N4) ? rs2_q[idx*4 +: 4] : 4'h0;
      end
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      cnt_q <= '0;
      op_q  <= 1'b0;
      rs1_q <= '0;
      rs2_q <= '0;
      res_q <= '0;
    end else if (accept) begin
      cnt_q <= '0;
      op_q  <= op_xperm8_i;
      rs1_q <= rs1_i;
      rs2_q <= rs2_i;
      res_q <= '0;
    end else if (state_q == BUSY) begin
      res_q <= res_d;
      if (!last_step) cnt_q <= cnt_q + 4'd1;
    end
  end

  assign rd_o = res_q;

endmodule

// File: tb/tb_crypto_fu_xperm_seq.sv
// Self-checking bench for crypto_fu_xperm_seq: three configurations checked every cycle
// against a transaction-level xperm model, with literal vectors pinning the model.
module tb_crypto_fu_xperm_seq;

  localparam int ND = 3;

  logic          clk_i = 1'b0;
  logic          rst_i;
  logic [ND-1:0] valid_i, ready_i, op_i, valid_o, ready_o;
  logic [63:0]   rs1 [ND];
  logic [63:0]   rs2 [ND];
  logic [63:0]   rd0, rd2;
  logic [31:0]   rd1;

  int checks   = 0;
  int failures = 0;
  int timeouts = 0;
  int timeouts_seen = 0;

  bit          busy    [ND];
  int          elapsed [ND];
  int          exp_s   [ND];
  logic [63:0] exp_rd  [ND];
  bit          pin_on  [ND];
  logic [63:0] pin_rd  [ND];
  int          pin_lat [ND];

  always #5 clk_i = ~clk_i;

  crypto_fu_xperm_seq #(.XLEN(64), .EPC(4)) u_x64e4 (
    .clk_i(clk_i), .rst_i(rst_i), .valid_i(valid_i[0]), .ready_o(ready_o[0]),
    .op_xperm8_i(op_i[0]), .rs1_i(rs1[0]), .rs2_i(rs2[0]),
    .valid_o(valid_o[0]), .ready_i(ready_i[0]), .rd_o(rd0));

  crypto_fu_xperm_seq #(.XLEN(32), .EPC(1)) u_x32e1 (
    .clk_i(clk_i), .rst_i(rst_i), .valid_i(valid_i[1]), .ready_o(ready_o[1]),
    .op_xperm8_i(op_i[1]), .rs1_i(rs1[1][31:0]), .rs2_i(rs2[1][31:0]),
    .valid_o(valid_o[1]), .ready_i(ready_i[1]), .rd_o(rd1));

  crypto_fu_xperm_seq #(.XLEN(64), .EPC(16)) u_x64e16 (
    .clk_i(clk_i), .rst_i(rst_i), .valid_i(valid_i[2]), .ready_o(ready_o[2]),
    .op_xperm8_i(op_i[2]), .rs1_i(rs1[2]), .rs2_i(rs2[2]),
    .valid_o(valid_o[2]), .ready_i(ready_i[2]), .rd_o(rd2));

  function automatic int xlen_of(int d);
    return (d == 1) ? 32 : 64;
  endfunction

  function automatic int epc_of(int d);
    case (d)
      0:       return 4;
      1:       return 1;
      default: return 16;
    endcase
  endfunction

  function automatic int steps_of(int d, bit x8);
    int n = xlen_of(d) / (x8 ? 8 : 4);
    int s = n / epc_of(d);
    return (s < 1) ? 1 : s;
  endfunction

  function automatic logic [63:0] rd_of(int d);
    case (d)
      0:       return rd0;
      1:       return {32'h0, rd1};
      default: return rd2;
    endcase
  endfunction

  // Whole-register xperm: each result element looks up the table element its index names.
  function automatic logic [63:0] xperm_ref(int xlen, bit x8, logic [63:0] idxv, logic [63:0] tbl);
    int          w = x8 ? 8 : 4;
    int          n = xlen / w;
    logic [63:0] m = x8 ? 64'hFF : 64'hF;
    logic [63:0] r = '0;
    for (int i = 0; i < n; i++) begin
      int ix = int'((idxv >> (i * w)) & m);
      if (ix < n) r = r | (((tbl >> (ix * w)) & m) << (i * w));
    end
    return r;
  endfunction

  task automatic checkOutput(string name, logic [63:0] actual, logic [63:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s: actual=%h required=%h at %0t", name, actual, expected, $time);
    end
  endtask

  // Compare process: outputs are checked on every falling edge, then the model advances
  // using the inputs that the next rising edge will sample.
  always @(negedge clk_i) begin
    bit ev;
    for (int d = 0; d < ND; d++) begin
      if (rst_i) begin
        checkOutput($sformatf("rst_ready%0d", d), 64'(ready_o[d]), 64'd1);
        checkOutput($sformatf("rst_valid%0d", d), 64'(valid_o[d]), 64'd0);
        checkOutput($sformatf("rst_rd%0d", d), rd_of(d), 64'd0);
        busy[d]    = 1'b0;
        elapsed[d] = 0;
      end else begin
        ev = busy[d] && (elapsed[d] >= exp_s[d]);
        checkOutput($sformatf("ready%0d", d), 64'(ready_o[d]), 64'(!busy[d]));
        checkOutput($sformatf("valid%0d", d), 64'(valid_o[d]), 64'(ev));
        if (ev) checkOutput($sformatf("rd%0d", d), rd_of(d), exp_rd[d]);
        if (ev && elapsed[d] == exp_s[d] && pin_on[d]) begin
          checkOutput($sformatf("pin_rd%0d", d), exp_rd[d], pin_rd[d]);
          checkOutput($sformatf("pin_lat%0d", d), 64'(exp_s[d]), 64'(pin_lat[d]));
        end
        if (!busy[d]) begin
          if (valid_i[d]) begin
            busy[d]    = 1'b1;
            elapsed[d] = 0;
            exp_s[d]   = steps_of(d, op_i[d]);
            exp_rd[d]  = xperm_ref(xlen_of(d), op_i[d], rs1[d], rs2[d]);
          end
        end else if (ev && ready_i[d]) begin
          busy[d] = 1'b0;
        end else begin
          elapsed[d]++;
        end
      end
    end
    if (timeouts != timeouts_seen) begin
      checkOutput("wait_valid_timeout", 64'(timeouts), 64'(timeouts_seen));
      timeouts_seen = timeouts;
    end
  end

  task automatic applyStimulus(int d, bit x8, logic [63:0] a, logic [63:0] b);
    @(posedge clk_i); #1;
    valid_i[d] = 1'b1;
    op_i[d]    = x8;
    rs1[d]     = a;
    rs2[d]     = b;
    @(posedge clk_i); #1;
    valid_i[d] = 1'b0;
  endtask

  task automatic waitValid(int d, int budget);
    int n = 0;
    while (!valid_o[d] && n < budget) begin
      @(posedge clk_i); #1;
      n++;
    end
    if (!valid_o[d]) timeouts++;
  endtask

  task automatic runPinned(int d, bit x8, logic [63:0] a, logic [63:0] b,
                           logic [63:0] want, int lat);
    pin_on[d]  = 1'b1;
    pin_rd[d]  = want;
    pin_lat[d] = lat;
    applyStimulus(d, x8, a, b);
    waitValid(d, 20);
    repeat (3) @(posedge clk_i);
    #1;
    pin_on[d] = 1'b0;
  endtask

  task automatic runRandom(int d, int count);
    int hold;
    for (int k = 0; k < count; k++) begin
      ready_i[d] = 1'b0;
      applyStimulus(d, 1'($urandom_range(0, 1)), {$urandom, $urandom}, {$urandom, $urandom});
      waitValid(d, 20);
      hold = $urandom_range(0, 3);
      repeat (hold) @(posedge clk_i);
      #1;
      ready_i[d] = 1'b1;
      @(posedge clk_i); #1;
    end
    ready_i[d] = 1'b1;
  endtask

  initial begin
    #500000;
    $display("[TB] FAIL watchdog expired");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    rst_i   = 1'b1;
    valid_i = '0;
    ready_i = '1;
    op_i    = '0;
    for (int d = 0; d < ND; d++) begin
      rs1[d]    = '0;
      rs2[d]    = '0;
      pin_on[d] = 1'b0;
    end
    repeat (2) @(posedge clk_i);
    #2 rst_i = 1'b0;

    $display("[TB] directed vectors");
    runPinned(0, 1'b0, 64'h0123456789ABCDEF, 64'hFEDCBA9876543210, 64'h0123456789ABCDEF, 4);
    runPinned(0, 1'b1, 64'h00000000000000FF, 64'h8877665544332211, 64'h1111111111111100, 2);
    runPinned(1, 1'b0, 64'h00000000000000F8, 64'h000000007654321A, 64'h00000000AAAAAA00, 8);
    runPinned(2, 1'b0, 64'h0123456789ABCDEF, 64'hFEDCBA9876543210, 64'h0123456789ABCDEF, 1);
    runPinned(2, 1'b1, 64'h00000000000000FF, 64'h8877665544332211, 64'h1111111111111100, 1);

    $display("[TB] backpressure in DONE");
    ready_i[0] = 1'b0;
    applyStimulus(0, 1'b0, 64'h76543210FEDCBA98, 64'h0F1E2D3C4B5A6978);
    waitValid(0, 20);
    for (int k = 0; k < 10; k++) begin
      @(posedge clk_i); #1;
      valid_i[0] = ~valid_i[0];
      op_i[0]    = ~op_i[0];
      rs1[0]     = {$urandom, $urandom};
      rs2[0]     = {$urandom, $urandom};
    end
    @(posedge clk_i); #1;
    valid_i[0] = 1'b0;
    ready_i[0] = 1'b1;
    @(posedge clk_i); #1;
    ready_i[0] = 1'b0;
    repeat (2) @(posedge clk_i);
    #1 ready_i[0] = 1'b1;

    $display("[TB] reset during BUSY");
    applyStimulus(0, 1'b0, 64'h0123456789ABCDEF, 64'hFEDCBA9876543210);
    @(posedge clk_i); #2;
    rst_i = 1'b1;
    @(posedge clk_i); #2;
    rst_i = 1'b0;
    repeat (20) @(posedge clk_i);

    $display("[TB] randomised operands");
    runRandom(2, 20);
    runRandom(0, 10);
    runRandom(1, 8);

    repeat (3) @(posedge clk_i);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/crypto_fu_xperm_seq.md
# crypto_fu_xperm_seq

Sequential, parametrised crossbar-permute unit for the crypto functional unit. It executes RISC-V xperm4 (nibble lookup) and xperm8 (byte lookup) for XLEN 32 or 64 and resolves a configurable number of result elements per cycle. Out-of-range indices produce zero. It sits behind the FU issue stage with valid/ready handshakes on both the operand side and the result side.

## Interface
Parameters:
- XLEN, 64: datapath width. Legal values are 32 and 64.
- EPC, 4: result elements resolved per cycle. Legal values are 1, 2, 4, 8 and 16.

Ports:
- clk_i  in  1  clock, rising edge.
- rst_i  in  1  reset. One clock; reset is asynchronous and active-high.
- valid_i  in  1  operands valid.
- ready_o  out  1  unit can accept operands.
- op_xperm8_i  in  1  0 = xperm4, 1 = xperm8.
- rs1_i  in  XLEN  index vector.
- rs2_i  in  XLEN  lookup table.
- valid_o  out  1  result valid.
- ready_i  in  1  consumer accepts result.
- rd_o  out  XLEN  result register.

## Operation
- Element width W is 4 for xperm4 and 8 for xperm8. Element count N = XLEN/W: 16 or 8 for xperm4, 8 or 4 for xperm8.
- Result rule: element i of rd = rs2 element[idx] when idx = rs1 element i and idx < N. Otherwise element i = 0.
- For XLEN=64 xperm4, every index is in range. Under xperm8 and under XLEN=32 xperm4, the upper index values are out of range and yield zero.
- Step count S = max(1, N/EPC).
- FSM states are IDLE, BUSY and DONE.
  - IDLE: ready_o=1. On valid_i && ready_o the unit latches rs1_i, rs2_i and op_xperm8_i, clears the result register and the step counter, then moves to BUSY.
  - BUSY: each cycle the unit resolves elements [cnt*EPC, cnt*EPC+EPC-1] (capped at N-1), writes them into the result register and increments cnt. After step S-1 it moves to DONE.
  - DONE: valid_o=1. rd_o, and the whole result register, are held stable. On ready_i the unit returns to IDLE.
- ready_o = (state==IDLE). valid_o = (state==DONE). Both come from registered state only. There is no combinational path from valid_i or ready_i to any output.
- Operands are captured on acceptance. Changes on rs1_i, rs2_i or op_xperm8_i after acceptance have no effect.
- valid_i outside IDLE is ignored. Nothing is queued.
- rd_o always shows the result register. Before DONE it holds partial results; the consumer uses it only while valid_o=1.
- Element counter width is 4 bits. The counter never wraps, because the exit to DONE is decided on cnt == S-1.

## Timing
- Reset values: state=IDLE, ready_o=1, valid_o=0, rd_o=0, cnt=0. Reset takes effect immediately on rst_i rising, independent of clk_i.
- Latency: with acceptance at edge E0, valid_o rises after edge E_S, i.e. S cycles after acceptance.
  - XLEN=64, EPC=4: xperm4 takes 4 cycles, xperm8 takes 2.
- Throughput: one operation per S+2 cycles when ready_i is held high. The extra two cycles are one in DONE and one back in IDLE; there are no back-to-back accepts.
- Backpressure: DONE holds indefinitely while ready_i=0.
- Handshake in DONE: a ready_i pulse of one cycle completes the transfer. ready_o rises in the following cycle.
- Reset mid-operation in BUSY or DONE: the operation is discarded. No valid_o is produced after rst_i is released.

## Test plan
- XLEN=64, EPC=4, xperm4. rs2=0xFEDCBA9876543210, rs1=0x0123456789ABCDEF -> rd_o=0x0123456789ABCDEF. valid_o high exactly 4 cycles after acceptance.
- XLEN=64, xperm8. rs2=0x8877665544332211, rs1=0x00000000000000FF -> rd_o=0x1111111111111100, because byte 0 has idx 0xFF, which is out of range. valid_o after 2 cycles.
- XLEN=32, EPC=1, xperm4. rs2=0x7654321A, rs1=0x000000F8 -> rd_o=0xAAAAAA00, because idx 8 and idx 0xF are out of range. valid_o after 8 cycles.
- Backpressure:
  - Hold ready_i=0 for 10 cycles in DONE, while toggling valid_i and changing the operands.
  - Required: rd_o and valid_o=1 stay stable and ready_o=0.
  - Then pulse ready_i for one cycle. Required: valid_o=0 and ready_o=1 on the next cycle.
- Reset mid-BUSY:
  - Assert rst_i between clock edges during step 1. Required: ready_o=1, valid_o=0 and rd_o=0 immediately.
  - After release with valid_i=0, valid_o stays 0 for 20 cycles.
- XLEN=64, EPC=16, xperm4: 1-cycle latency with a correct result. Also randomised operands against a reference model, with results compared at every valid_o&&ready_i.
